// File: rtl/lb_responder_pkg.sv
// Shared constants, decode helper and read-pipe slot type for lb_responder.
// Holds the local-bus register map and N_CFG.
package lb_responder_pkg;

    localparam logic [23:0] ADDR_ID       = 24'h000000;
    localparam logic [23:0] ADDR_WCNT     = 24'h000001;
    localparam logic [23:0] ADDR_RCNT     = 24'h000002;
    localparam logic [23:0] ADDR_ERR      = 24'h000003;
    localparam logic [23:0] ADDR_CFG_BASE = 24'h000010;
    localparam logic [23:0] ADDR_PULSE    = 24'h000020;

    localparam int N_CFG = 16;

    typedef enum logic [2:0] {
        SEL_ID,
        SEL_WCNT,
        SEL_RCNT,
        SEL_ERR,
        SEL_CFG,
        SEL_PULSE,
        SEL_NONE
    } sel_e;

    typedef struct packed {
        logic        tok;
        logic [31:0] data;
    } rd_slot_t;

    function automatic sel_e decode(input logic [23:0] addr);
        sel_e sel;
        sel = SEL_NONE;
        unique case (1'b1)
            addr == ADDR_ID:   sel = SEL_ID;
            addr == ADDR_WCNT: sel = SEL_WCNT;
            addr == ADDR_RCNT: sel = SEL_RCNT;
            addr == ADDR_ERR:  sel = SEL_ERR;
            addr[23:4] == ADDR_CFG_BASE[23:4]:
                sel = SEL_CFG;
            addr == ADDR_PULSE: sel = SEL_PULSE;
            default:           sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lb_responder_read_pipe.sv
// lb_read_pipe: delays {token, data} so read data lands on lb_rdata READ_LAT
// cycles after the strobe; ports: rd_tok/rd_data in, lb_rvalid in, lb_rdata/lat_mismatch out.
module lb_read_pipe
    import lb_responder_pkg::*;
#(
    parameter int READ_LAT = 3
) (
    input  logic        lb_clk,
    input  logic        rst,
    input  logic        rd_tok,
    input  logic [31:0] rd_data,
    input  logic        lb_rvalid,
    output logic [31:0] lb_rdata,
    output logic        lat_mismatch
);

    localparam int DEPTH = READ_LAT - 1;

    rd_slot_t pipe [DEPTH];
    logic     tok_q;

    // The lb_rdata flop is the last stage, so tokens travel READ_LAT
    // flops in total and tok_q lines up with the initiator's lb_rvalid.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
            tok_q    <= 1'b0;
            lb_rdata <= '0;
        end else begin
            pipe[0] <= '{tok: rd_tok, data: rd_data};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
            tok_q <= pipe[DEPTH-1].tok;
            if (pipe[DEPTH-1].tok) begin
                lb_rdata <= pipe[DEPTH-1].data;
            end
        end
    end

    assign lat_mismatch = tok_q ^ lb_rvalid;

endmodule

// File: rtl/lb_responder.sv
// Local-bus responder: register decode, cfg/pulse registers, traffic and
// error counters; ports: lb_* bus in, lb_rdata out, cfg_regs/cfg_pulse/lat_err out.
module lb_responder
    import lb_responder_pkg::*;
#(
    parameter int          READ_LAT = 3,
    parameter logic [31:0] ID_WORD  = 32'h4C425231,
    parameter logic [31:0] UNMAPPED = 32'hDEADF00D
) (
    input  logic                  lb_clk,
    input  logic                  rst,
    input  logic                  lb_valid,
    input  logic                  lb_rnw,
    input  logic [23:0]           lb_addr,
    input  logic [31:0]           lb_wdata,
    input  logic                  lb_rvalid,
    output logic [31:0]           lb_rdata,
    output logic [N_CFG*32-1:0]   cfg_regs,
    output logic [31:0]           cfg_pulse,
    output logic                  lat_err
);

    sel_e        sel;
    logic        rd;
    logic        wr;
    logic [8:0]  cfg_off;
    logic [31:0] rd_data;
    logic [31:0] wcnt;
    logic [31:0] rcnt;
    logic [15:0] err_cnt;
    logic [15:0] err_nxt;
    logic [16:0] err_sum;
    logic [1:0]  err_ev;
    logic        unmapped;
    logic        mism;
    logic        err_clr;

    assign sel      = decode(lb_addr);
    assign rd       = lb_valid & lb_rnw;
    assign wr       = lb_valid & ~lb_rnw;
    assign cfg_off  = {lb_addr[3:0], 5'd0};
    assign unmapped = lb_valid & (sel == SEL_NONE);
    assign err_clr  = wr & (sel == SEL_ERR);

    // Reads see the registers as they are this cycle, so a write in the
    // previous cycle is already visible.
    always_comb begin
        rd_data = UNMAPPED;
        unique case (sel)
            SEL_ID:    rd_data = ID_WORD;
            SEL_WCNT:  rd_data = wcnt;
            SEL_RCNT:  rd_data = rcnt;
            SEL_ERR:   rd_data = {16'h0, err_cnt};
            SEL_CFG:   rd_data = cfg_regs[cfg_off +: 32];
            SEL_PULSE: rd_data = '0;
            default:   rd_data = UNMAPPED;
        endcase
    end

    // Up to two events per cycle; bit 16 of the sum flags saturation.
    always_comb begin
        err_ev  = {1'b0, unmapped} + {1'b0, mism};
        err_sum = {1'b0, err_cnt} + {15'd0, err_ev};
        err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (err_clr) begin
            err_nxt = '0;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            cfg_regs  <= '0;
            cfg_pulse <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            err_cnt   <= '0;
            lat_err   <= 1'b0;
        end else begin
            if (wr && sel == SEL_CFG) begin
                cfg_regs[cfg_off +: 32] <= lb_wdata;
            end
            cfg_pulse <= (wr && sel == SEL_PULSE) ? lb_wdata : '0;
            wcnt      <= wcnt + {31'd0, wr};
            rcnt      <= rcnt + {31'd0, rd};
            err_cnt   <= err_nxt;
            lat_err   <= (err_nxt != '0);
        end
    end

    lb_read_pipe #(
        .READ_LAT (READ_LAT)
    ) u_read_pipe (
        .lb_clk       (lb_clk),
        .rst          (rst),
        .rd_tok       (rd),
        .rd_data      (rd_data),
        .lb_rvalid    (lb_rvalid),
        .lb_rdata     (lb_rdata),
        .lat_mismatch (mism)
    );

endmodule

// File: tb/tb_lb_responder.sv
// Self-checking bench for lb_responder: vector table, scoreboard of read
// data, and directed latency/saturation/reset sequences.
module tb_lb_responder;

    localparam int LAT = 3;
    localparam logic [31:0] IDW = 32'h4C425231;
    localparam logic [31:0] UNM = 32'hDEADF00D;

    logic         lb_clk;
    logic         rst;
    logic         lb_valid;
    logic         lb_rnw;
    logic [23:0]  lb_addr;
    logic [31:0]  lb_wdata;
    logic         lb_rvalid;
    logic [31:0]  lb_rdata;
    logic [511:0] cfg_regs;
    logic [31:0]  cfg_pulse;
    logic         lat_err;

    lb_responder #(
        .READ_LAT (LAT)
    ) dut (
        .lb_clk    (lb_clk),
        .rst       (rst),
        .lb_valid  (lb_valid),
        .lb_rnw    (lb_rnw),
        .lb_addr   (lb_addr),
        .lb_wdata  (lb_wdata),
        .lb_rvalid (lb_rvalid),
        .lb_rdata  (lb_rdata),
        .cfg_regs  (cfg_regs),
        .cfg_pulse (cfg_pulse),
        .lat_err   (lat_err)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    typedef struct {
        int          due;
        logic [31:0] val;
        bit          chk;
    } sb_t;

    typedef struct {
        bit          rnw;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    sb_t   exp_q[$];
    vec_t  tbl[21];
    bit    rv_plan  [0:65535];
    bit    tok_plan [0:65535];
    int    cyc_n;
    int    rv_dly;
    int    n_chk;
    int    n_fail;

    logic [31:0] m_cfg [16];
    logic [31:0] m_wcnt;
    logic [31:0] m_rcnt;
    logic [15:0] m_err;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, expv, cyc_n);
        end
    endtask

    function automatic bit mapped(input logic [23:0] a);
        return (a <= 24'h3) || (a[23:4] == 20'h1) || (a == 24'h20);
    endfunction

    function automatic logic [31:0] model_rd(input logic [23:0] a);
        if (a == 24'h0) return IDW;
        if (a == 24'h1) return m_wcnt;
        if (a == 24'h2) return m_rcnt;
        if (a == 24'h3) return {16'h0, m_err};
        if (a[23:4] == 20'h1) return m_cfg[a[3:0]];
        if (a == 24'h20) return 32'h0;
        return UNM;
    endfunction

    task automatic step(input bit v, input bit rnw, input logic [23:0] a,
                        input logic [31:0] wd, input logic [31:0] expv,
                        input bit chk);
        bit          rv;
        bit          tok;
        bit          un;
        bit          mm;
        int          s;
        logic [31:0] pexp;
        sb_t         e;
        rv  = rv_plan[cyc_n];
        tok = tok_plan[cyc_n];
        lb_valid  = v;
        lb_rnw    = rnw;
        lb_addr   = a;
        lb_wdata  = wd;
        lb_rvalid = rv;
        if (rv && exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
            e = exp_q.pop_front();
            if (e.chk) check("rdata", lb_rdata, e.val);
        end
        if (v && rnw) begin
            exp_q.push_back('{cyc_n + LAT, expv, chk});
            tok_plan[cyc_n + LAT] = 1'b1;
            rv_plan[cyc_n + LAT + rv_dly] = 1'b1;
            m_rcnt++;
        end
        pexp = '0;
        if (v && !rnw) begin
            m_wcnt++;
            if (a[23:4] == 20'h1) m_cfg[a[3:0]] = wd;
            if (a == 24'h20) pexp = wd;
        end
        un = v && !mapped(a);
        mm = tok ^ rv;
        if (v && !rnw && a == 24'h3) begin
            m_err = '0;
        end else begin
            s = int'(m_err) + int'(un) + int'(mm);
            m_err = (s > 65535) ? 16'hFFFF : 16'(s);
        end
        @(posedge lb_clk);
        #1;
        cyc_n++;
        check("cfg_pulse", cfg_pulse, pexp);
        check("lat_err", 32'(lat_err), 32'(m_err != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rd_model(input logic [23:0] a);
        step(1'b1, 1'b1, a, 32'h0, model_rd(a), 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < 16; i++) tok_plan[cyc_n + i] = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_cfg[i] = '0;
        m_wcnt = '0;
        m_rcnt = '0;
        m_err  = '0;
        rst      = 1'b1;
        lb_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            lb_rvalid = rv_plan[cyc_n];
            @(posedge lb_clk);
            #1;
            cyc_n++;
        end
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc_n  = 0;
        rv_dly = 0;
        lb_valid = 0; lb_rnw = 0; lb_addr = '0;
        lb_wdata = '0; lb_rvalid = 0; rst = 1;

        tbl[0]  = '{1'b1, 24'h000000, 32'h0,        IDW};
        tbl[1]  = '{1'b0, 24'h000013, 32'h12345678, 32'h0};
        tbl[2]  = '{1'b1, 24'h000013, 32'h0,        32'h12345678};
        tbl[3]  = '{1'b0, 24'h000020, 32'h00000005, 32'h0};
        tbl[4]  = '{1'b1, 24'h000001, 32'h0,        32'd2};
        tbl[5]  = '{1'b1, 24'h000002, 32'h0,        32'd3};
        tbl[6]  = '{1'b1, 24'h000020, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, 24'h0ABCDE, 32'h0,        UNM};
        tbl[8]  = '{1'b1, 24'h000003, 32'h0,        32'd1};
        tbl[9]  = '{1'b0, 24'h000003, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 24'h000003, 32'h0,        32'd0};
        tbl[11] = '{1'b1, 24'h000010, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 24'h00001F, 32'hA5A5A5A5, 32'h0};
        tbl[13] = '{1'b1, 24'h00001F, 32'h0,        32'hA5A5A5A5};
        tbl[14] = '{1'b1, 24'h000002, 32'h0,        32'd10};
        tbl[15] = '{1'b0, 24'h000000, 32'hFFFFFFFF, 32'h0};
        tbl[16] = '{1'b1, 24'h000000, 32'h0,        IDW};
        tbl[17] = '{1'b1, 24'h000003, 32'h0,        32'd0};
        tbl[18] = '{1'b1, 24'h000001, 32'h0,        32'd5};
        tbl[19] = '{1'b1, 24'h100010, 32'h0,        UNM};
        tbl[20] = '{1'b1, 24'h000003, 32'h0,        32'd1};

        do_reset(3);
        check("reset lb_rdata", lb_rdata, 32'h0);
        check("reset cfg_pulse", cfg_pulse, 32'h0);
        check("reset lat_err", 32'(lat_err), 32'h0);
        check("reset cfg_regs", 32'(cfg_regs != '0), 32'h0);

        for (int i = 0; i < 21; i++) begin
            step(1'b1, tbl[i].rnw, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp, tbl[i].rnw);
        end
        idle(5);
        check("cfg_regs[127:96]", cfg_regs[127:96], 32'h12345678);
        check("cfg_regs[511:480]", cfg_regs[511:480], 32'hA5A5A5A5);
        check("cfg_regs[31:0]", cfg_regs[31:0], 32'h0);

        // back-to-back write then read-after-write, every cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 24'h10 + 24'(i), 32'h1111_1111 * (i + 1) ^ 32'h0F0F_0000,
                 32'h0, 1'b0);
            rd_model(24'h10 + 24'(i));
        end
        rd_model(24'h1);
        rd_model(24'h2);
        rd_model(24'h2);
        idle(5);

        // clear errors, then 8 reads answered one cycle late
        step(1'b1, 1'b0, 24'h3, 32'h0, 32'h0, 1'b0);
        rv_dly = 1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 24'h0, 32'h0, IDW, 1'b0);
            idle(1);
        end
        rv_dly = 0;
        idle(5);
        step(1'b1, 1'b1, 24'h3, 32'h0, 32'd16, 1'b1);
        idle(5);

        // drive the error counter into saturation
        while (m_err != 16'hFFFF) begin
            rv_plan[cyc_n] = 1'b1;
            step(1'b1, 1'b0, 24'h000800, 32'h0, 32'h0, 1'b0);
        end
        idle(5);
        step(1'b1, 1'b1, 24'h3, 32'h0, 32'h0000FFFF, 1'b1);
        step(1'b1, 1'b0, 24'h000800, 32'h0, 32'h0, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 24'h3, 32'h0, 32'h0000FFFF, 1'b1);
        idle(5);

        // clear and error event in the same cycle: clear wins
        rv_plan[cyc_n] = 1'b1;
        step(1'b1, 1'b0, 24'h3, 32'h0, 32'h0, 1'b0);
        check("lat_err after clear", 32'(lat_err), 32'h0);
        idle(2);
        step(1'b1, 1'b1, 24'h3, 32'h0, 32'd0, 1'b1);
        idle(5);

        // reset one cycle after a read strobe; stray rvalid follows
        step(1'b1, 1'b1, 24'h0, 32'h0, IDW, 1'b1);
        do_reset(1);
        check("flush lb_rdata", lb_rdata, 32'h0);
        idle(2);
        check("stray lat_err", 32'(lat_err), 32'h1);
        check("stray lb_rdata", lb_rdata, 32'h0);
        step(1'b1, 1'b1, 24'h3, 32'h0, 32'd1, 1'b1);
        idle(5);

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
